// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM state encoding
// and a constant-foldable ceil(log2) used to size pointers and counters.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_SEND      = 2'd1,
    ARB_WAIT_BUSY = 2'd2,
    ARB_WAIT_DONE = 2'd3
  } arb_state_e;

  // Minimum 1 so single-bit indices never collapse to zero width.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational one-hot round-robin selector: the first asserted request at
// or after ptr+1 (with wrap) wins; all-zero grant when nothing is requesting.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt
);

  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter between
// N_REQ byte streams. Optional busy timeout: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int DW       = 8,
  parameter int HOLD_MAX = 64,
  parameter int TO_CYC   = 32
) (
  input  logic              clk,
  input  logic              i_reset_n,
  input  logic [N_REQ-1:0]  i_req,
  input  logic [N_REQ*DW-1:0] i_data,
  input  logic [N_REQ-1:0]  i_last,
  output logic [N_REQ-1:0]  o_ack,
  output logic [N_REQ-1:0]  o_grant,
  output logic              o_tx_start,
  output logic [DW-1:0]     o_tx_data,
  input  logic              i_tx_busy,
  output logic              o_err
);

  localparam int PW = clog2(N_REQ);
  localparam int CW = clog2(HOLD_MAX + 1);

  arb_state_e       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    g_q, g_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             start_q, start_d;
  logic [DW-1:0]    data_q, data_d;
  logic [N_REQ-1:0] pick;
  logic [PW-1:0]    pick_idx;
  logic             timeout;

  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_rr_pick (
    .req (i_req),
    .ptr (ptr_q),
    .gnt (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick[i]) pick_idx = pick_idx | PW'(i);
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = clog2(TO_CYC + 1);

  logic [TW-1:0] to_q;
  logic          err_q;

  // Counts consecutive WAIT_BUSY cycles with busy still low.
  assign timeout = (state_q == ARB_WAIT_BUSY) && !i_tx_busy && (to_q == TW'(TO_CYC - 1));

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
      if (state_q == ARB_WAIT_BUSY && !i_tx_busy && !timeout) to_q <= to_q + 1'b1;
      else                                                    to_q <= '0;
    end
  end

  assign o_err = err_q;
`else
  logic [31:0] unused_to_cyc;
  assign unused_to_cyc = TO_CYC;
  assign timeout       = 1'b0;
  assign o_err         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    grant_d = grant_q;
    ack_d   = '0;
    start_d = 1'b0;
    cnt_d   = cnt_q;
    last_d  = last_q;
    data_d  = data_q;

    case (state_q)
      ARB_IDLE: begin
        if (|i_req) begin
          grant_d = pick;
          g_d     = pick_idx;
          ack_d   = pick;
          start_d = 1'b1;
          data_d  = i_data[pick_idx*DW +: DW];
          cnt_d   = '0;
          state_d = ARB_SEND;
        end
      end
      ARB_SEND: begin
        cnt_d   = (cnt_q == CW'(HOLD_MAX)) ? cnt_q : cnt_q + 1'b1;
        last_d  = i_last[g_q];
        state_d = ARB_WAIT_BUSY;
      end
      ARB_WAIT_BUSY: begin
        if (timeout) begin
          ptr_d   = g_q;
          grant_d = '0;
          state_d = ARB_IDLE;
        end else if (i_tx_busy) begin
          state_d = ARB_WAIT_DONE;
        end
      end
      ARB_WAIT_DONE: begin
        if (!i_tx_busy) begin
          if (last_q || !i_req[g_q] || cnt_q == CW'(HOLD_MAX)) begin
            ptr_d   = g_q;
            grant_d = '0;
            state_d = ARB_IDLE;
          end else begin
            // Same owner keeps the grant: reload without re-arbitrating.
            ack_d   = grant_q;
            start_d = 1'b1;
            data_d  = i_data[g_q*DW +: DW];
            state_d = ARB_SEND;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of evaluation order.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= PW'(N_REQ - 1);
      g_q     <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      start_q <= start_d;
      data_q  <= data_d;
    end
  end

  assign o_ack      = ack_q;
  assign o_grant    = grant_q;
  assign o_tx_start = start_q;
  assign o_tx_data  = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues feed the DUT, a UART
// model answers starts with busy, and a monitor pops expected bytes per start.
module tb_uart_tx_arbiter;

  localparam int N        = 2;
  localparam int DW       = 8;
  localparam int HM       = 4;
  localparam int TO       = 32;
  localparam int BUSY_CYC = 4;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } src_t;

  typedef struct {
    int            g;
    logic [DW-1:0] d;
    int            gap;
  } exp_t;

  logic            clk;
  logic            i_reset_n;
  logic [N-1:0]    i_req;
  logic [N*DW-1:0] i_data;
  logic [N-1:0]    i_last;
  logic [N-1:0]    o_ack;
  logic [N-1:0]    o_grant;
  logic            o_tx_start;
  logic [DW-1:0]   o_tx_data;
  logic            i_tx_busy;
  logic            o_err;

  src_t  src_q[N][$];
  exp_t  exp_q[$];
  logic [N-1:0] pend = '0;
  logic  uart_en = 1'b1;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    fall_cyc = 0;
  int    start_cyc = 0;

  uart_tx_arbiter #(.N_REQ(N), .DW(DW), .HOLD_MAX(HM), .TO_CYC(TO)) dut (
    .clk        (clk),
    .i_reset_n  (i_reset_n),
    .i_req      (i_req),
    .i_data     (i_data),
    .i_last     (i_last),
    .o_ack      (o_ack),
    .o_grant    (o_grant),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .i_tx_busy  (i_tx_busy),
    .o_err      (o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requesters: present the queue head; drop it the cycle after its ack.
  initial begin
    i_req  = '0;
    i_data = '0;
    i_last = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (pend[k]) begin
          if (src_q[k].size() > 0) void'(src_q[k].pop_front());
          pend[k] = 1'b0;
        end
        if (o_ack[k] === 1'b1) pend[k] = 1'b1;
        if (src_q[k].size() > 0) begin
          i_req[k]             = 1'b1;
          i_data[k*DW +: DW]   = src_q[k][0].data;
          i_last[k]            = src_q[k][0].last;
        end else begin
          i_req[k] = 1'b0;
        end
      end
    end
  end

  // UART model: busy rises one cycle after start and lasts BUSY_CYC cycles.
  initial begin
    i_tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (o_tx_start === 1'b1 && uart_en) begin
        @(posedge clk);
        #1 i_tx_busy = 1'b1;
        repeat (BUSY_CYC) @(posedge clk);
        #1 i_tx_busy = 1'b0;
        fall_cyc = cyc;
      end
    end
  end

  // Monitor: each start must match the next expected owner, byte and gap.
  initial forever begin
    @(negedge clk);
    if (o_tx_start === 1'b1) begin
      exp_t e;
      logic [N-1:0] want;
      start_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_start: grant=%b data=%h, required no start", o_grant, o_tx_data);
      end else begin
        e = exp_q.pop_front();
        want = '0;
        want[e.g] = 1'b1;
        if (o_grant !== want || o_ack !== want || o_tx_data !== e.d) begin
          errors++;
          $display("FAIL start_byte: grant=%b ack=%b data=%h, required grant=ack=%b data=%h",
                   o_grant, o_ack, o_tx_data, want, e.d);
        end
        if (e.gap != 0) begin
          checks++;
          if (cyc - fall_cyc != e.gap) begin
            errors++;
            $display("FAIL start_gap: data=%h gap=%0d, required %0d", e.d, cyc - fall_cyc, e.gap);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic push_src(input int k, input logic [DW-1:0] d, input logic l);
    src_t s;
    s.last = l;
    s.data = d;
    src_q[k].push_back(s);
  endtask

  task automatic push_exp(input int g, input logic [DW-1:0] d, input int gap);
    exp_t e;
    e.g   = g;
    e.d   = d;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic clear_sources();
    for (int k = 0; k < N; k++) src_q[k].delete();
    pend = '0;
    exp_q.delete();
  endtask

  task automatic wait_busy_low();
    int n = 0;
    while (i_tx_busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 i_reset_n = 1'b0;
    clear_sources();
    repeat (2) @(posedge clk);
    wait_busy_low();
    @(negedge clk);
    i_reset_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while (!(exp_q.size() == 0 && o_grant === '0 && i_tx_busy === 1'b0 &&
             src_q[0].size() == 0 && src_q[1].size() == 0)) begin
      @(negedge clk);
      n++;
      if (n > max_cyc) begin
        checks++;
        errors++;
        $display("FAIL %s_drain: %0d expected bytes left after %0d cycles, required 0",
                 name, exp_q.size(), max_cyc);
        break;
      end
    end
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    #2;
    checks++; if (o_grant !== '0)     begin errors++; $display("FAIL reset_grant: %b, required 0", o_grant); end
    checks++; if (o_ack !== '0)       begin errors++; $display("FAIL reset_ack: %b, required 0", o_ack); end
    checks++; if (o_tx_start !== 1'b0) begin errors++; $display("FAIL reset_start: %b, required 0", o_tx_start); end
    checks++; if (o_tx_data !== '0)   begin errors++; $display("FAIL reset_data: %h, required 0", o_tx_data); end
    checks++; if (o_err !== 1'b0)     begin errors++; $display("FAIL reset_err: %b, required 0", o_err); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (o_grant !== '0 || o_tx_start !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: grant=%b start=%b, required 0/0", o_grant, o_tx_start);
    end
  endtask

  task automatic test_single();
    int n;
    apply_reset();
    @(posedge clk);
    #1 push_src(0, 8'h41, 1'b1);
    push_exp(0, 8'h41, 0);
    @(negedge clk); #1;
    checks++; if (o_tx_start !== 1'b0) begin errors++; $display("FAIL single_early_start: %b, required 0", o_tx_start); end
    @(negedge clk); #1;
    checks++; if (o_tx_start !== 1'b1 || o_ack !== 2'b01 || o_grant !== 2'b01 || o_tx_data !== 8'h41) begin
      errors++;
      $display("FAIL single_latency: start=%b ack=%b grant=%b data=%h, required 1/01/01/41",
               o_tx_start, o_ack, o_grant, o_tx_data);
    end
    n = 0;
    while (i_tx_busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    while (i_tx_busy !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    #1;
    checks++; if (o_grant !== 2'b01) begin errors++; $display("FAIL single_hold: grant=%b, required 01", o_grant); end
    @(negedge clk); #1;
    checks++; if (o_grant !== 2'b00 || o_tx_start !== 1'b0) begin
      errors++; $display("FAIL single_release: grant=%b start=%b, required 00/0", o_grant, o_tx_start);
    end
    wait_drain("single", 50);
  endtask

  task automatic test_packet_lock();
    apply_reset();
    @(posedge clk);
    #1;
    push_src(0, 8'h10, 1'b0); push_src(0, 8'h11, 1'b0); push_src(0, 8'h12, 1'b1);
    push_src(1, 8'h20, 1'b1);
    push_exp(0, 8'h10, 0); push_exp(0, 8'h11, 1); push_exp(0, 8'h12, 1);
    push_exp(1, 8'h20, 2);
    wait_drain("packet_lock", 200);
  endtask

  task automatic test_fairness();
    apply_reset();
    @(posedge clk);
    #1;
    push_src(0, 8'hA0, 1'b1); push_src(0, 8'hA1, 1'b1);
    push_src(1, 8'hB0, 1'b1); push_src(1, 8'hB1, 1'b1);
    push_exp(0, 8'hA0, 0); push_exp(1, 8'hB0, 2);
    push_exp(0, 8'hA1, 2); push_exp(1, 8'hB1, 2);
    wait_drain("fairness", 200);
  endtask

  task automatic test_hold_max();
    apply_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) push_src(0, 8'(8'h30 + i), 1'b0);
    push_src(1, 8'h50, 1'b1);
    for (int i = 0; i < 4; i++) push_exp(0, 8'(8'h30 + i), (i == 0) ? 0 : 1);
    push_exp(1, 8'h50, 2);
    for (int i = 4; i < 8; i++) push_exp(0, 8'(8'h30 + i), (i == 4) ? 2 : 1);
    push_exp(0, 8'h38, 2);
    push_exp(0, 8'h39, 1);
    wait_drain("hold_max", 400);
  endtask

  task automatic test_reset_mid();
    int n;
    apply_reset();
    @(posedge clk);
    #1;
    push_src(0, 8'h60, 1'b0); push_src(0, 8'h61, 1'b0); push_src(0, 8'h62, 1'b0);
    push_exp(0, 8'h60, 0);
    n = 0;
    while (i_tx_busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    #1 i_reset_n = 1'b0;
    clear_sources();
    #1;
    checks++; if (o_grant !== '0 || o_ack !== '0 || o_tx_start !== 1'b0 || o_tx_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: grant=%b ack=%b start=%b data=%h, required all 0",
               o_grant, o_ack, o_tx_start, o_tx_data);
    end
    wait_busy_low();
    @(negedge clk);
    i_reset_n = 1'b1;
    @(posedge clk);
    #1;
    push_src(1, 8'h77, 1'b1);
    push_exp(1, 8'h77, 0);
    wait_drain("reset_mid", 100);
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    apply_reset();
    uart_en = 1'b0;
    @(posedge clk);
    #1;
    push_src(0, 8'h99, 1'b1);
    push_exp(0, 8'h99, 0);
    n = 0;
    while (o_err !== 1'b1 && n < 80) begin @(negedge clk); n++; end
    checks++; if (o_err !== 1'b1) begin
      errors++; $display("FAIL timeout_err: no err pulse within 80 cycles, required one");
    end else begin
      checks++; if (cyc - start_cyc != TO + 1) begin
        errors++; $display("FAIL timeout_delay: %0d cycles, required %0d", cyc - start_cyc, TO + 1);
      end
      checks++; if (o_grant !== '0) begin errors++; $display("FAIL timeout_grant: %b, required 0", o_grant); end
      @(negedge clk);
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL timeout_pulse: err=%b, required 0", o_err); end
    end
    uart_en = 1'b1;
    wait_drain("timeout", 50);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_packet_lock();
    test_fairness();
    test_hold_max();
    test_reset_mid();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter between `N_REQ` byte-stream requesters (CPU console, FIFO echo path, debug dump). Grants are locked per packet, so a requester's bytes are never interleaved with another's. Sits between the requesters and the UART TX core, driving its start/data inputs and following its busy flag.

## Interface
- `N_REQ`, 2: number of requesters, 2..8
- `DW`, 8: byte width
- `HOLD_MAX`, 64: maximum bytes per grant before forced release
- `TO_CYC`, 32: busy-assert timeout in cycles (used only with `UART_ARB_TIMEOUT_EN`)

- `clk` in 1: system clock
- `i_reset_n` in 1: reset, asynchronous and active-low
- `i_req` in N_REQ: requester has a byte valid
- `i_data` in N_REQ*DW: byte of requester k at [k*DW +: DW]
- `i_last` in N_REQ: presented byte ends the packet
- `o_ack` out N_REQ: one-cycle pulse, byte of requester k consumed
- `o_grant` out N_REQ: one-hot current owner, 0 when idle
- `o_tx_start` out 1: one-cycle pulse to UART TX
- `o_tx_data` out DW: byte to UART TX, stable from start until release of busy
- `i_tx_busy` in 1: UART TX shifting
- `o_err` out 1: one-cycle timeout pulse (0 without the macro)

## Operation
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE: if any `i_req`, pick the winner by round-robin, searching from `ptr+1` upward with wrap. Register `o_grant`, `o_tx_data` and `o_ack[g]`, pulse `o_tx_start`, clear `cnt`, then go to SEND.
- SEND (1 cycle): increment `cnt`; latch `last_q = i_last[g]` at the ack. Go to WAIT_BUSY.
- WAIT_BUSY: stay until `i_tx_busy`=1, then go to WAIT_DONE.
- WAIT_DONE: stay until `i_tx_busy`=0. Then:
  - Release when any of these holds: `last_q`, `i_req[g]`=0, or `cnt`==HOLD_MAX. On release: `ptr <= g`, `o_grant <= 0`, go to IDLE.
  - Otherwise load the next byte of the same requester exactly as IDLE does (ack, start) and go to SEND.
- `ptr` resets to N_REQ-1, so requester 0 wins first.
- `cnt` is width clog2(HOLD_MAX+1) and saturates; no wrap is possible because release occurs at HOLD_MAX.
- A requester must hold `i_data` and `i_last` stable while `i_req`=1 and until `o_ack`. It may change them the cycle after `o_ack`.
- Requests from non-granted requesters are ignored (no ack) until release.
- Reset mid-packet: all state is cleared immediately. The UART may still finish its current byte; the arbiter ignores busy until it is back in IDLE.

## Timing
- Reset values: `o_ack`=0, `o_grant`=0, `o_tx_start`=0, `o_tx_data`=0, `o_err`=0, state IDLE.
- All outputs are registered.
- Latency: `i_req` sampled high at edge n → `o_grant`, `o_ack`, `o_tx_start` high after edge n (cycle n+1).
- Back-to-back bytes within a grant: next start is one cycle after busy falls.
- Arbitration gap: a released grant returns to IDLE for one cycle. The earliest next start is 2 cycles after busy falls.
- Simultaneous requests at release: the new winner is the lowest index above the old owner, with wrap.

## Configuration
- `UART_ARB_TIMEOUT_EN`
  - Defined: a cycle counter runs in WAIT_BUSY. If `i_tx_busy` stays low for TO_CYC cycles, the block pulses `o_err` and forces release (grant cleared, `ptr` advanced, IDLE).
  - Undefined: no counter, `o_err` is tied 0, and WAIT_BUSY waits forever.

## Structure
- Package `uart_arb_pkg`: state enum, `ARB_IDLE/SEND/WAIT_BUSY/WAIT_DONE` encodings, clog2 helper.
- Sub-module `rr_pick`: combinational one-hot round-robin selector, with inputs `req` and `ptr` and output `gnt`. Instantiated once.

## Test plan
- Single request: after reset, req0=1, data0=0x41, last0=1 → start and ack0 one cycle later, `o_tx_data`=0x41, grant released after busy falls.
- Packet lock: req0 sends 3 bytes 0x10,0x11,0x12 (last on 0x12) while req1 is held high → three starts, all with grant0, before any ack1.
- Fairness: req0 and req1 held high with last=1 on every byte → grants alternate 0,1,0,1 over 4 bytes.
- HOLD_MAX: HOLD_MAX=4, req0 streams 10 bytes with last=0, req1 high → release after 4 bytes, grant1 next.
- Reset mid-packet: assert `i_reset_n`=0 during WAIT_DONE → all outputs 0 immediately; after reset, req1 alone is granted first time.
- Timeout (macro defined): start issued with `i_tx_busy` held 0 → `o_err` pulse after 32 cycles, grant 0, IDLE.
